// File: rtl/uart_autobaud.sv
// Auto-baud controller: measures a 0x55 sync character on the gated RX line and
// drives the uart_rx bit length with the rounded period, else passes the software value.
module uart_autobaud #(
    parameter int CNT_W       = 24,
    parameter int MIN_BIT_CYC = 4
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_enable,
    input  logic        i_rx,
    input  logic [31:0] i_sw_bit_length,
    output logic        o_rx_core,
    output logic [31:0] o_bit_length,
    output logic        o_busy,
    output logic        o_locked,
    output logic        o_done,
    output logic        o_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_MEASURE,
        S_CALC,
        S_RELEASE,
        S_ERROR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next;
    logic             r_rx_q;
    logic             r_en_q;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_seg;
    logic [CNT_W-1:0] r_s0;
    logic [CNT_W-1:0] r_T;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_rel_cnt;
    logic [CNT_W-1:0] r_measured;
    logic [2:0]       r_edges;
    logic             r_locked;
    logic             r_error;
    logic             r_done;

    logic             w_fe;
    logic             w_en_rise;
    logic [CNT_W-1:0] w_seg_inc;
    logic [CNT_W-1:0] w_p;
    logic             w_tol_err;
    logic             w_rel_ok;
    logic             w_success;

    // Eight bit times were measured, so divide by 8 with round-to-nearest.
    function automatic logic [CNT_W-1:0] round_div8(input logic [CNT_W-1:0] t);
        logic [CNT_W:0] sum;
        sum = {1'b0, t} + (CNT_W+1)'(4);
        return CNT_W'(sum >> 3);
    endfunction

    function automatic logic out_of_tol(input logic [CNT_W-1:0] iv,
                                        input logic [CNT_W-1:0] s0);
        logic [CNT_W-1:0] diff;
        diff = (iv >= s0) ? (iv - s0) : (s0 - iv);
        return diff > (s0 >> 2);
    endfunction

    assign w_fe      = r_rx_q & ~i_rx;
    assign w_en_rise = i_enable & ~r_en_q;
    assign w_seg_inc = r_seg + CNT_W'(1);
    assign w_p       = round_div8(r_T);
    // Edges 3..5 are compared against the first interval; r_edges is the pre-increment count.
    assign w_tol_err = (r_edges >= 3'd2) && out_of_tol(w_seg_inc, r_s0);
    assign w_rel_ok  = i_rx && (r_rel_cnt == r_period - CNT_W'(1));
    assign w_success = (r_state == S_RELEASE) && i_enable && (r_total != CNT_MAX) && w_rel_ok;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (w_en_rise) w_next = S_WAIT_START;
            S_WAIT_START: if (w_fe) w_next = S_MEASURE;
            S_MEASURE: begin
                if (r_total == CNT_MAX)              w_next = S_ERROR;
                else if (w_fe && w_tol_err)          w_next = S_ERROR;
                else if (w_fe && r_edges == 3'd4)    w_next = S_CALC;
            end
            S_CALC: begin
                if (w_p < CNT_W'(MIN_BIT_CYC)) w_next = S_ERROR;
                else                           w_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (r_total == CNT_MAX) w_next = S_ERROR;
                else if (w_rel_ok)      w_next = S_IDLE;
            end
            S_ERROR:      w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
        if (r_state != S_IDLE && !i_enable) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state    <= S_IDLE;
            r_rx_q     <= 1'b1;
            r_en_q     <= 1'b0;
            r_total    <= '0;
            r_seg      <= '0;
            r_s0       <= '0;
            r_T        <= '0;
            r_period   <= '0;
            r_rel_cnt  <= '0;
            r_measured <= '0;
            r_edges    <= '0;
            r_locked   <= 1'b0;
            r_error    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rx_q  <= i_rx;
            r_en_q  <= i_enable;
            r_done  <= w_success || (w_next == S_ERROR);
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_WAIT_START) begin
                        r_locked <= 1'b0;
                        r_error  <= 1'b0;
                    end
                end
                S_WAIT_START: begin
                    if (w_fe) begin
                        r_total <= '0;
                        r_seg   <= '0;
                        r_edges <= 3'd1;
                    end
                end
                S_MEASURE: begin
                    r_total <= r_total + CNT_W'(1);
                    r_seg   <= w_seg_inc;
                    if (w_fe) begin
                        r_edges <= r_edges + 3'd1;
                        r_seg   <= '0;
                        if (r_edges == 3'd1) r_s0 <= w_seg_inc;
                        if (r_edges == 3'd4) r_T  <= r_total + CNT_W'(1);
                    end
                end
                S_CALC: begin
                    r_period  <= w_p;
                    r_total   <= '0;
                    r_rel_cnt <= '0;
                    if (w_next == S_RELEASE) begin
                        r_measured <= w_p - CNT_W'(1);
                        r_locked   <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    // r_total doubles as the stuck-low watchdog while waiting for the stop bit.
                    r_total   <= r_total + CNT_W'(1);
                    r_rel_cnt <= i_rx ? (r_rel_cnt + CNT_W'(1)) : '0;
                end
                default: ;
            endcase
            if (w_next == S_ERROR) begin
                r_error  <= 1'b1;
                r_locked <= 1'b0;
            end
            if (r_state != S_IDLE && !i_enable) r_locked <= 1'b0;
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_rx_core    = o_busy ? 1'b1 : i_rx;
    assign o_bit_length = r_locked ? 32'(r_measured) : i_sw_bit_length;
    assign o_locked     = r_locked;
    assign o_done       = r_done;
    assign o_error      = r_error;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: table of sync-character attempts plus
// hand-written timeout, abort and asynchronous-reset sequences.
module tb_uart_autobaud;

    localparam logic [31:0] SW  = 32'h0000_1234;
    localparam logic [31:0] SW2 = 32'h0000_0ABC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        rx;
    logic [31:0] sw;

    logic        rxc, busy, locked, done, err;
    logic [31:0] blen;
    logic        rxc8, busy8, locked8, done8, err8;
    logic [31:0] blen8;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_cnt8 = 0;
    int leak = 0;

    uart_autobaud #(.CNT_W(24), .MIN_BIT_CYC(4)) dut (
        .i_clk(clk), .i_nrst(rst_n), .i_enable(en), .i_rx(rx), .i_sw_bit_length(sw),
        .o_rx_core(rxc), .o_bit_length(blen), .o_busy(busy), .o_locked(locked),
        .o_done(done), .o_error(err)
    );

    uart_autobaud #(.CNT_W(8), .MIN_BIT_CYC(4)) dut8 (
        .i_clk(clk), .i_nrst(rst_n), .i_enable(en), .i_rx(rx), .i_sw_bit_length(sw),
        .o_rx_core(rxc8), .o_bit_length(blen8), .o_busy(busy8), .o_locked(locked8),
        .o_done(done8), .o_error(err8)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)  done_cnt++;
        if (done8) done_cnt8++;
        if (busy && !rxc) leak++;
    end

    typedef struct {
        int          n;
        int          kind;
        logic [31:0] sw;
        logic        exp_lock;
        logic        exp_err;
        logic [31:0] exp_len;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame bits: start(0), 8 data LSB first, stop(1); jit skews edges by a few clocks.
    task automatic send_frame(input logic [7:0] b, input int n, input bit jit, input int nb);
        logic [9:0] f;
        int d[10];
        f = {1'b1, b, 1'b0};
        d = '{1, 0, 0, -1, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < nb; i++) begin
            rx = f[i];
            tick(n + (jit ? d[i] : 0));
        end
    endtask

    initial begin
        int d0, l0, d8;
        vecs[0] = '{16,  0, SW,  1'b1, 1'b0, 32'd15};
        vecs[1] = '{100, 1, SW,  1'b1, 1'b0, 32'd99};
        vecs[2] = '{16,  2, SW,  1'b0, 1'b1, SW};
        vecs[3] = '{2,   0, SW,  1'b0, 1'b1, SW};
        vecs[4] = '{4,   0, SW,  1'b1, 1'b0, 32'd3};
        vecs[5] = '{8,   0, SW2, 1'b1, 1'b0, 32'd7};
        vecs[6] = '{3,   0, SW2, 1'b0, 1'b1, SW2};

        rst_n = 1'b0; en = 1'b0; rx = 1'b1; sw = SW;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_error", err, 0);
        chk("rst_done", done, 0);
        chk("rst_bitlen", blen, SW);
        rx = 1'b0; #1;
        chk("rst_rxcore", rxc, 0);
        rx = 1'b1;
        rst_n = 1'b1;
        tick(2);

        for (int v = 0; v < 7; v++) begin
            sw = vecs[v].sw;
            d0 = done_cnt; l0 = leak;
            en = 1'b0; tick(2);
            en = 1'b1; tick(3);
            chk($sformatf("v%0d_busy_wait", v), busy, 1);
            case (vecs[v].kind)
                0: send_frame(8'h55, vecs[v].n, 1'b0, 10);
                1: send_frame(8'h55, vecs[v].n, 1'b1, 10);
                default: begin
                    send_frame(8'h00, vecs[v].n, 1'b0, 10);
                    rx = 1'b1; tick(5 * vecs[v].n);
                    send_frame(8'h00, vecs[v].n, 1'b0, 10);
                    send_frame(8'h00, vecs[v].n, 1'b0, 10);
                end
            endcase
            rx = 1'b1;
            tick(3 * vecs[v].n + 20);
            chk($sformatf("v%0d_locked", v), locked, vecs[v].exp_lock);
            chk($sformatf("v%0d_error", v), err, vecs[v].exp_err);
            chk($sformatf("v%0d_bitlen", v), blen, vecs[v].exp_len);
            chk($sformatf("v%0d_busy_end", v), busy, 0);
            chk($sformatf("v%0d_done_pulses", v), done_cnt - d0, 1);
            chk($sformatf("v%0d_gate_leak", v), leak - l0, 0);
            if (vecs[v].exp_lock) begin
                sw = ~vecs[v].sw;
                tick(1);
                chk($sformatf("v%0d_sw_ignored", v), blen, vecs[v].exp_len);
                sw = vecs[v].sw;
            end else begin
                rx = 1'b0; #1;
                chk($sformatf("v%0d_rx_follow", v), rxc, 0);
                rx = 1'b1;
            end
        end

        // Timeout on the 8-bit counter instance: one edge, then the line stays high.
        en = 1'b0; tick(2);
        d8 = done_cnt8; d0 = done_cnt;
        en = 1'b1; tick(3);
        rx = 1'b0; tick(1);
        rx = 1'b1; tick(200);
        chk("to_not_early", busy8, 1);
        for (int i = 0; i < 100 && done_cnt8 == d8; i++) tick(1);
        chk("to_done", done_cnt8 - d8, 1);
        tick(2);
        chk("to_error", err8, 1);
        chk("to_busy", busy8, 0);
        chk("to_locked", locked8, 0);
        rx = 1'b0; #1;
        chk("to_rx_follow", rxc8, 0);
        rx = 1'b1;

        // The wide instance is still measuring: abort it.
        chk("abort_pre_busy", busy, 1);
        en = 1'b0; tick(1);
        chk("abort_idle", busy, 0);
        chk("abort_locked", locked, 0);
        tick(3);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_error", err, 0);

        // Asynchronous reset while waiting for the stop bit.
        sw = SW;
        en = 1'b1; tick(3);
        send_frame(8'h55, 16, 1'b0, 9);
        rx = 1'b1; tick(5);
        chk("rel_busy", busy, 1);
        chk("rel_locked", locked, 1);
        chk("rel_bitlen", blen, 32'd15);
        #2 rst_n = 1'b0;
        rx = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_locked", locked, 0);
        chk("arst_error", err, 0);
        chk("arst_done", done, 0);
        chk("arst_bitlen", blen, SW);
        chk("arst_rxcore", rxc, 0);
        rx = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
